// File: rtl/mem_pkg.sv
// Shared types and constants for the memory read-return path.
package mem_pkg;
  typedef enum logic [1:0] {IDLE, REQ, SEND, DONE} state_e;

  localparam int DATA_W    = 8;
  localparam int BUS_W     = 10;
  localparam int VALID_BIT = 9;
  localparam int READ_BIT  = 8;
  localparam int ID_W      = 2;

  typedef struct packed {
    logic              last;
    logic [DATA_W-1:0] data;
  } rx_entry_t;
endpackage

// File: rtl/mem_read_return_port_if.sv
// Receive-byte stream, ack-bus arbitration and return data bus of the read-return port.
interface mem_read_return_port_if;
  import mem_pkg::*;

  logic [DATA_W-1:0] in_rx_data;
  logic              in_rx_last;
  logic              in_rx_valid;
  logic              out_rx_ready;
  logic [ID_W-1:0]   in_dest_id;
  logic              out_ack_req;
  logic [ID_W-1:0]   out_ack_id;
  logic              in_ack_owned;
  logic              out_bus_valid;
  logic              out_bus_read;
  logic [DATA_W-1:0] out_bus_data;
  logic              out_done;

  modport slave (
    input  in_rx_data, in_rx_last, in_rx_valid, in_dest_id, in_ack_owned,
    output out_rx_ready, out_ack_req, out_ack_id, out_bus_valid, out_bus_read,
           out_bus_data, out_done
  );

  modport master (
    output in_rx_data, in_rx_last, in_rx_valid, in_dest_id, in_ack_owned,
    input  out_rx_ready, out_ack_req, out_ack_id, out_bus_valid, out_bus_read,
           out_bus_data, out_done
  );
endinterface

// File: rtl/mem_sync_fifo.sv
// Single-clock FIFO; no pass-through when full and no bypass when empty.
module mem_sync_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rptr_q];

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
      count_q <= count_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end

  // Storage is left unreset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= wdata_i;
  end
endmodule

// File: rtl/mem_read_return_port.sv
// Buffers flash read bytes, arbitrates for the ack bus and returns them as registered beats.
module mem_read_return_port
  import mem_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  mem_read_return_port_if.slave   rp
);
  rx_entry_t          wentry, head;
  logic               push, pop, full, empty;
  state_e             state_q;
  logic               ack_req_q;
  logic [ID_W-1:0]    ack_id_q, dest_q;
  logic               burst_open_q;
  logic [BUS_W-1:0]   bus_q;
  logic               done_q;

  assign wentry = '{last: rp.in_rx_last, data: rp.in_rx_data};
  assign push   = rp.in_rx_valid && !full;
  assign pop    = (state_q == SEND) && rp.in_ack_owned && !empty;

  mem_sync_fifo #(.WIDTH($bits(rx_entry_t)), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .wdata_i (wentry),
    .pop_i   (pop),
    .rdata_o (head),
    .full_o  (full),
    .empty_o (empty)
  );

  assign rp.out_rx_ready  = !full;
  assign rp.out_ack_req   = ack_req_q;
  assign rp.out_ack_id    = ack_id_q;
  assign rp.out_bus_valid = bus_q[VALID_BIT];
  assign rp.out_bus_read  = bus_q[READ_BIT];
  assign rp.out_bus_data  = bus_q[DATA_W-1:0];
  assign rp.out_done      = done_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      ack_req_q    <= 1'b0;
      ack_id_q     <= '0;
      dest_q       <= '0;
      burst_open_q <= 1'b0;
      bus_q        <= '0;
      done_q       <= 1'b0;
    end else begin
      // Requester ID belongs to the first byte of each burst.
      if (push) begin
        if (!burst_open_q) dest_q <= rp.in_dest_id;
        burst_open_q <= !rp.in_rx_last;
      end

      bus_q[VALID_BIT] <= pop;
      bus_q[READ_BIT]  <= pop;
      if (pop) bus_q[DATA_W-1:0] <= head.data;
      done_q <= pop && head.last;

      case (state_q)
        IDLE: if (!empty) begin
          state_q   <= REQ;
          ack_req_q <= 1'b1;
          ack_id_q  <= dest_q;
        end
        REQ: if (rp.in_ack_owned) state_q <= SEND;
        SEND: begin
          if (!rp.in_ack_owned) begin
            state_q <= REQ;
          end else if (pop && head.last) begin
            state_q   <= DONE;
            ack_req_q <= 1'b0;
          end
        end
        DONE: begin
          // One released cycle, then straight back into arbitration if more is queued.
          if (!empty) begin
            state_q   <= REQ;
            ack_req_q <= 1'b1;
            ack_id_q  <= dest_q;
          end else begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule
